// File: rtl/cnn_pkg.sv
// cnn_pkg
// Shared definitions for the LeNet-5 conv front end.
//   DEF_IMG_W / DEF_IMG_H : default image geometry in pixels
//   DEF_K                 : default kernel size (window array is K x K)
//   DEF_DW                : default pixel width
//   WIN_COUNT             : complete windows produced per frame at defaults
//   ctrl_state_t          : sequencing state of window_ctrl
package cnn_pkg;

    localparam int DEF_IMG_W = 32;
    localparam int DEF_IMG_H = 32;
    localparam int DEF_K     = 5;
    localparam int DEF_DW    = 8;

    localparam int WIN_COUNT = (DEF_IMG_W - DEF_K + 1) * (DEF_IMG_H - DEF_K + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } ctrl_state_t;

endpackage

// File: rtl/raster_counter.sv
// raster_counter
// Column/row position of the next pixel in raster order.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : synchronous return to (0,0), used when a frame starts
//   en        : advance one pixel position
//   col, row  : current position
//   last_pix  : current position is the final pixel of the frame
// Advancing from the final pixel wraps both counters back to zero.
module raster_counter #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     en,
    output logic [$clog2(IMG_W)-1:0] col,
    output logic [$clog2(IMG_H)-1:0] row,
    output logic                     last_pix
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    assign last_pix = (col == COL_LAST) && (row == ROW_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/window_ctrl.sv
// window_ctrl
// Sequencing controller for the KxK sliding-window array.
//   clk, rst    : clock, asynchronous active-high reset
//   start       : begin a frame (honoured only when idle)
//   s_valid/s_data/s_ready : raster-order pixel stream in
//   shift_en    : shift strobe for window array and line buffers
//   pix_out     : pixel presented to the window row input
//   lb_addr     : line-buffer column address
//   win_valid/m_ready : window handshake with the conv engine
//   win_row/win_col   : top-left coordinate of the held window
//   busy        : a frame is in progress
//   frame_done  : one-cycle pulse after the frame is fully consumed
module window_ctrl
    import cnn_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int K     = DEF_K,
    parameter int DW    = DEF_DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     s_valid,
    input  logic [DW-1:0]            s_data,
    output logic                     s_ready,
    output logic                     shift_en,
    output logic [DW-1:0]            pix_out,
    output logic [$clog2(IMG_W)-1:0] lb_addr,
    output logic                     win_valid,
    input  logic                     m_ready,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);

    ctrl_state_t   state;
    ctrl_state_t   state_next;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          last_pix;
    logic          start_ok;
    logic          qualify;
    logic          frame_done_next;

    raster_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_raster_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_ok),
        .en       (shift_en),
        .col      (col),
        .row      (row),
        .last_pix (last_pix)
    );

    // A held, unconsumed window blocks new pixels so the window array
    // stays frozen while the conv engine applies backpressure.
    assign s_ready  = (state == RUN) && (!win_valid || m_ready);
    assign shift_en = s_valid && s_ready;
    assign pix_out  = s_data;
    assign lb_addr  = col;
    assign busy     = (state != IDLE);

    // The shift that completes a full in-image patch; earlier columns of
    // each row and the first K-1 rows only prime the line buffers.
    assign qualify = shift_en && (row >= ROW_FIRST) && (col >= COL_FIRST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            frame_done <= frame_done_next;
        end
    end

    // A start coinciding with the frame_done pulse is dropped so a
    // back-to-back request cannot be confused with the frame just ended.
    always_comb begin
        state_next      = state;
        start_ok        = 1'b0;
        frame_done_next = 1'b0;
        case (state)
            IDLE: begin
                if (start && !frame_done) begin
                    state_next = RUN;
                    start_ok   = 1'b1;
                end
            end
            RUN: begin
                if (shift_en && last_pix) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!win_valid || m_ready) begin
                    state_next      = IDLE;
                    frame_done_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A consume and a new qualifying shift in the same cycle keep the
    // window valid and simply load the next coordinates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else if (qualify) begin
            win_valid <= 1'b1;
            win_row   <= row - ROW_FIRST;
            win_col   <= col - COL_FIRST;
        end else if (m_ready) begin
            win_valid <= 1'b0;
        end
    end

endmodule
